// File: rtl/cam_capture_ctrl.sv
// Camera pixel-capture controller: synchronises the camera bus, assembles RGB444
// byte pairs, converts them to the output depth and writes them row-aligned to RAM.
module cam_capture_ctrl #(
  parameter int AW    = 15,
  parameter int DW    = 3,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic [7:0]    D,
  input  logic          PCLK,
  input  logic          HREF,
  input  logic          VSYNC,
  input  logic          start,
  input  logic          cont,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          frame_done,
  output logic          line_err,
  output logic [7:0]    frame_cnt
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int LW = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_VS   = 2'd1,
    S_CAPTURE   = 2'd2,
    S_FRAME_END = 2'd3
  } state_t;

  // RGB444 to output depth; widths other than 8 and 12 fall back to RGB111.
  function automatic logic [DW-1:0] conv_px(input logic [11:0] px);
    logic [11:0] t;
    case (DW)
      12:      t = px;
      8:       t = {4'h0, px[11:9], px[7:5], px[3:2]};
      default: t = {9'h000, px[11], px[7], px[3]};
    endcase
    return t[DW-1:0];
  endfunction

  state_t        state_r, state_next_s;
  logic          pclk_s1_r, pclk_s2_r, pclk_s3_r;
  logic          href_s1_r, href_s2_r, href_s3_r;
  logic          vs_s1_r, vs_s2_r, vs_s3_r;
  logic [7:0]    d_s1_r, d_s2_r;
  logic          cont_r;
  logic [CW-1:0] col_r, col_eff_s;
  logic [LW-1:0] line_r, line_eff_s;
  logic [AW-1:0] row_base_r;
  logic          phase_r, phase_eff_s;
  logic [3:0]    hi_r;
  logic          pix_vld_r;
  logic [AW-1:0] pix_addr_r;
  logic [DW-1:0] pix_data_r;
  logic          start_acc_s, cap_clr_s, err_set_s;

  // Two-flop synchroniser for all camera inputs plus one history flop for edge detection.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      pclk_s1_r <= 1'b0; pclk_s2_r <= 1'b0; pclk_s3_r <= 1'b0;
      href_s1_r <= 1'b0; href_s2_r <= 1'b0; href_s3_r <= 1'b0;
      vs_s1_r   <= 1'b0; vs_s2_r   <= 1'b0; vs_s3_r   <= 1'b0;
      d_s1_r    <= 8'h00; d_s2_r   <= 8'h00;
    end else begin
      pclk_s1_r <= PCLK;  pclk_s2_r <= pclk_s1_r; pclk_s3_r <= pclk_s2_r;
      href_s1_r <= HREF;  href_s2_r <= href_s1_r; href_s3_r <= href_s2_r;
      vs_s1_r   <= VSYNC; vs_s2_r   <= vs_s1_r;   vs_s3_r   <= vs_s2_r;
      d_s1_r    <= D;     d_s2_r    <= d_s1_r;
    end
  end

  logic pclk_rise_s, href_fall_s, vs_fall_s, vs_rise_s;
  logic in_cap_s, accept_s, px_done_s, col_full_s, line_full_s, wr_s, eol_s;

  assign pclk_rise_s = pclk_s2_r & ~pclk_s3_r;
  assign href_fall_s = href_s3_r & ~href_s2_r;
  assign vs_fall_s   = vs_s3_r & ~vs_s2_r;
  assign vs_rise_s   = vs_s2_r & ~vs_s3_r;

  // A byte clocked in the same cycle HREF drops is still accepted (href_s3 covers it).
  assign in_cap_s    = (state_r == S_CAPTURE);
  assign accept_s    = in_cap_s & pclk_rise_s & (href_s2_r | href_s3_r);
  assign px_done_s   = accept_s & phase_r;
  assign col_full_s  = (col_r >= CW'(IMG_W));
  assign line_full_s = (line_r >= LW'(IMG_H));
  assign wr_s        = px_done_s & ~col_full_s & ~line_full_s;
  assign eol_s       = in_cap_s & href_fall_s;

  // State register.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state_r <= S_IDLE;
    else      state_r <= state_next_s;
  end

  // Next-state logic and control strobes.
  always_comb begin
    state_next_s = state_r;
    start_acc_s  = 1'b0;
    cap_clr_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_WAIT_VS;
          start_acc_s  = 1'b1;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_WAIT_VS: begin
        if (vs_fall_s) begin
          state_next_s = S_CAPTURE;
          cap_clr_s    = 1'b1;
        end else begin
          state_next_s = S_WAIT_VS;
        end
      end
      S_CAPTURE: begin
        if (vs_rise_s) state_next_s = S_FRAME_END;
        else           state_next_s = S_CAPTURE;
      end
      S_FRAME_END: begin
        if (cont_r) state_next_s = S_WAIT_VS;
        else        state_next_s = S_IDLE;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Post-byte column/phase/line values, so end-of-line checks see a coincident byte.
  always_comb begin
    col_eff_s   = wr_s ? col_r + CW'(1) : col_r;
    phase_eff_s = accept_s ? ~phase_r : phase_r;
    line_eff_s  = (eol_s && !line_full_s) ? line_r + LW'(1) : line_r;
    err_set_s   = (px_done_s && col_full_s)
               || (eol_s && line_full_s)
               || (eol_s && !line_full_s && ((col_eff_s != CW'(IMG_W)) || phase_eff_s))
               || (in_cap_s && vs_rise_s && (line_eff_s != LW'(IMG_H)));
  end

  // Capture datapath: position counters, byte assembly and the pixel staging register.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      col_r      <= '0;
      line_r     <= '0;
      row_base_r <= '0;
      phase_r    <= 1'b0;
      hi_r       <= 4'h0;
      pix_vld_r  <= 1'b0;
      pix_addr_r <= '0;
      pix_data_r <= '0;
      cont_r     <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      if (cap_clr_s) begin
        col_r      <= '0;
        line_r     <= '0;
        row_base_r <= '0;
        phase_r    <= 1'b0;
      end else if (eol_s) begin
        col_r   <= '0;
        phase_r <= 1'b0;
        if (!line_full_s) begin
          row_base_r <= row_base_r + AW'(IMG_W);
          line_r     <= line_r + LW'(1);
        end
      end else begin
        phase_r <= phase_eff_s;
        col_r   <= col_eff_s;
      end
      if (accept_s && !phase_r) hi_r <= d_s2_r[3:0];
      pix_vld_r <= wr_s;
      if (wr_s) begin
        pix_addr_r <= row_base_r + AW'(col_r);
        pix_data_r <= conv_px({hi_r, d_s2_r});
      end
      if (start_acc_s) cont_r <= cont;
      if (start_acc_s)    line_err <= 1'b0;
      else if (err_set_s) line_err <= 1'b1;
    end
  end

  // Registered outputs; address/data hold their last written value.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      px_wr       <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 8'h00;
    end else begin
      px_wr <= pix_vld_r;
      if (pix_vld_r) begin
        mem_px_addr <= pix_addr_r;
        mem_px_data <= pix_data_r;
      end
      busy       <= (state_next_s != S_IDLE);
      frame_done <= (state_next_s == S_FRAME_END);
      if (state_next_s == S_FRAME_END) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: three instances (RGB111/332/444) on a 4x2 image
// share one camera bus; writes are logged and compared against hand-computed tables.
module tb_cam_capture_ctrl;
  localparam int AW = 4;
  localparam int W  = 4;
  localparam int H  = 2;

  logic CLK = 1'b0, rst = 1'b0;
  logic [7:0] D = 8'h00;
  logic PCLK = 1'b0, HREF = 1'b0, VSYNC = 1'b1, start = 1'b0, cont = 1'b0;

  logic [AW-1:0] a3, a8, a12;
  logic [2:0]    d3;
  logic [7:0]    d8;
  logic [11:0]   d12;
  logic wr3, wr8, wr12, busy3, busy8, busy12, fd3, fd8, fd12, err3, err8, err12;
  logic [7:0] cnt3, cnt8, cnt12;

  cam_capture_ctrl #(.AW(AW), .DW(3), .IMG_W(W), .IMG_H(H)) u_dut3 (
    .CLK(CLK), .rst(rst), .D(D), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC),
    .start(start), .cont(cont), .mem_px_addr(a3), .mem_px_data(d3), .px_wr(wr3),
    .busy(busy3), .frame_done(fd3), .line_err(err3), .frame_cnt(cnt3));
  cam_capture_ctrl #(.AW(AW), .DW(8), .IMG_W(W), .IMG_H(H)) u_dut8 (
    .CLK(CLK), .rst(rst), .D(D), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC),
    .start(start), .cont(cont), .mem_px_addr(a8), .mem_px_data(d8), .px_wr(wr8),
    .busy(busy8), .frame_done(fd8), .line_err(err8), .frame_cnt(cnt8));
  cam_capture_ctrl #(.AW(AW), .DW(12), .IMG_W(W), .IMG_H(H)) u_dut12 (
    .CLK(CLK), .rst(rst), .D(D), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC),
    .start(start), .cont(cont), .mem_px_addr(a12), .mem_px_data(d12), .px_wr(wr12),
    .busy(busy12), .frame_done(fd12), .line_err(err12), .frame_cnt(cnt12));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [2:0]  e3;
    logic [7:0]  e8;
    logic [11:0] e12;
  } vec_t;
  vec_t vec[8];

  int checks = 0, failures = 0;
  int cyc = 0, last_rise = 0, nfd = 0;
  logic [AW-1:0] qa[$];
  logic [2:0]    q3[$];
  logic [7:0]    q8[$];
  logic [11:0]   q12[$];
  int            qlat[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Write/frame_done logger, sampled away from the active edge.
  always @(negedge CLK) begin
    if (wr3) begin
      qa.push_back(a3);
      q3.push_back(d3);
      qlat.push_back(cyc - last_rise);
    end
    if (wr8)  q8.push_back(d8);
    if (wr12) q12.push_back(d12);
    if (fd3)  nfd++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_log();
    qa.delete(); q3.delete(); q8.delete(); q12.delete(); qlat.delete();
    nfd = 0;
  endtask

  task automatic cam_byte(input logic [7:0] b);
    D = b; PCLK = 1'b0;
    tick(4);
    PCLK = 1'b1; last_rise = cyc;
    tick(4);
  endtask

  task automatic send_line(input int npx, input int odd, input int tbase);
    HREF = 1'b1;
    for (int p = 0; p < npx; p++) begin
      if (tbase >= 0) begin
        cam_byte(vec[tbase + p].b0);
        cam_byte(vec[tbase + p].b1);
      end else begin
        cam_byte(8'h0F);
        cam_byte(8'hF0);
      end
    end
    if (odd != 0) cam_byte(8'h55);
    PCLK = 1'b0; HREF = 1'b0;
    tick(8);
  endtask

  task automatic send_frame(input int n0, input int o0, input int n1, input int o1, input int tbase);
    VSYNC = 1'b1; tick(6);
    VSYNC = 1'b0; tick(8);
    send_line(n0, o0, tbase);
    send_line(n1, o1, (tbase >= 0) ? tbase + 4 : -1);
    tick(4);
    VSYNC = 1'b1; tick(10);
  endtask

  task automatic pulse_start(input logic c);
    cont = c; start = 1'b1;
    tick(1);
    start = 1'b0; cont = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(3);
    rst = 1'b1; tick(3);
  endtask

  initial begin
    int exp_b[7];
    vec[0] = '{8'h0F, 8'hF0, 3'b110, 8'hFC, 12'hFF0};
    vec[1] = '{8'h08, 8'h08, 3'b101, 8'h82, 12'h808};
    vec[2] = '{8'h07, 8'h77, 3'b000, 8'h6D, 12'h777};
    vec[3] = '{8'h00, 8'h00, 3'b000, 8'h00, 12'h000};
    vec[4] = '{8'h0A, 8'h5C, 3'b101, 8'hAB, 12'hA5C};
    vec[5] = vec[0];
    vec[6] = vec[1];
    vec[7] = vec[2];
    exp_b = '{0, 1, 2, 4, 5, 6, 7};

    // Reset state
    tick(3);
    chk("rst_px_wr", 32'(wr3), 32'd0);
    chk("rst_busy", 32'(busy3), 32'd0);
    chk("rst_frame_done", 32'(fd3), 32'd0);
    chk("rst_line_err", 32'(err3), 32'd0);
    chk("rst_frame_cnt", 32'(cnt3), 32'd0);
    chk("rst_addr", 32'(a3), 32'd0);
    chk("rst_data12", 32'(d12), 32'd0);
    rst = 1'b1;
    tick(3);
    chk("idle_busy", 32'(busy3), 32'd0);

    // A: single frame from the vector table, all three depths
    clear_log();
    pulse_start(1'b0);
    chk("A_busy_after_start", 32'(busy3), 32'd1);
    send_frame(4, 0, 4, 0, 0);
    chk("A_nwr", 32'(qa.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("A_addr%0d", i), (i < qa.size()) ? 32'(qa[i]) : 32'hDEAD, 32'(i));
      chk($sformatf("A_rgb111_%0d", i), (i < q3.size()) ? 32'(q3[i]) : 32'hDEAD, 32'(vec[i].e3));
      chk($sformatf("A_rgb332_%0d", i), (i < q8.size()) ? 32'(q8[i]) : 32'hDEAD, 32'(vec[i].e8));
      chk($sformatf("A_rgb444_%0d", i), (i < q12.size()) ? 32'(q12[i]) : 32'hDEAD, 32'(vec[i].e12));
    end
    chk("A_latency", (qlat.size() > 0) ? 32'(qlat[0]) : 32'hDEAD, 32'd4);
    chk("A_frame_done", 32'(nfd), 32'd1);
    chk("A_frame_cnt", 32'(cnt3), 32'd1);
    chk("A_line_err", 32'(err3), 32'd0);
    chk("A_busy_end", 32'(busy3), 32'd0);
    send_frame(4, 0, 4, 0, -1);
    chk("A_single_no_wr", 32'(qa.size()), 32'd8);
    chk("A_single_cnt", 32'(cnt3), 32'd1);

    // B: short first line keeps rows aligned, address 3 skipped
    clear_log();
    pulse_start(1'b0);
    send_frame(3, 0, 4, 0, -1);
    chk("B_nwr", 32'(qa.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("B_addr%0d", i), (i < qa.size()) ? 32'(qa[i]) : 32'hDEAD, 32'(exp_b[i]));
      chk($sformatf("B_data%0d", i), (i < q3.size()) ? 32'(q3[i]) : 32'hDEAD, 32'd6);
    end
    chk("B_line_err", 32'(err3), 32'd1);
    chk("B_frame_cnt", 32'(cnt3), 32'd2);

    // C: over-long lines and a trailing odd byte
    clear_log();
    pulse_start(1'b0);
    chk("C_err_cleared", 32'(err3), 32'd0);
    send_frame(6, 0, 6, 1, -1);
    chk("C_nwr", 32'(qa.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("C_addr%0d", i), (i < qa.size()) ? 32'(qa[i]) : 32'hDEAD, 32'(i));
    chk("C_line_err", 32'(err3), 32'd1);
    chk("C_frame_cnt", 32'(cnt3), 32'd3);

    // D: continuous capture over three frames
    do_reset();
    clear_log();
    pulse_start(1'b1);
    for (int f = 0; f < 3; f++) send_frame(4, 0, 4, 0, -1);
    chk("D_nwr", 32'(qa.size()), 32'd24);
    for (int i = 0; i < 24; i++)
      chk($sformatf("D_addr%0d", i), (i < qa.size()) ? 32'(qa[i]) : 32'hDEAD, 32'(i % 8));
    chk("D_frame_cnt", 32'(cnt3), 32'd3);
    chk("D_frame_done", 32'(nfd), 32'd3);
    chk("D_busy", 32'(busy3), 32'd1);
    chk("D_line_err", 32'(err3), 32'd0);

    // F: start inside a frame waits for the next VSYNC fall
    do_reset();
    clear_log();
    VSYNC = 1'b1; tick(6);
    VSYNC = 1'b0; tick(8);
    pulse_start(1'b0);
    send_line(4, 0, -1);
    send_line(4, 0, -1);
    VSYNC = 1'b1; tick(10);
    chk("F_no_partial", 32'(qa.size()), 32'd0);
    chk("F_busy_wait", 32'(busy3), 32'd1);
    send_frame(4, 0, 4, 0, -1);
    chk("F_nwr", 32'(qa.size()), 32'd8);
    chk("F_frame_cnt", 32'(cnt3), 32'd1);
    chk("F_busy_end", 32'(busy3), 32'd0);

    // G: asynchronous reset in the middle of a line
    clear_log();
    pulse_start(1'b0);
    VSYNC = 1'b1; tick(6);
    VSYNC = 1'b0; tick(8);
    HREF = 1'b1;
    cam_byte(8'h0F); cam_byte(8'hF0);
    cam_byte(8'h08); cam_byte(8'h08);
    chk("G_wr_before_rst", 32'(wr3), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("G_async_px_wr", 32'(wr3), 32'd0);
    chk("G_async_busy", 32'(busy3), 32'd0);
    chk("G_async_addr", 32'(a3), 32'd0);
    chk("G_async_data", 32'(d3), 32'd0);
    chk("G_async_cnt", 32'(cnt3), 32'd0);
    @(negedge CLK);
    rst = 1'b1;
    cam_byte(8'h07); cam_byte(8'h77);
    cam_byte(8'h00); cam_byte(8'h00);
    PCLK = 1'b0; HREF = 1'b0; tick(8);
    send_line(4, 0, -1);
    VSYNC = 1'b1; tick(10);
    send_frame(4, 0, 4, 0, -1);
    chk("G_no_wr_after_rst", 32'(qa.size()), 32'd2);
    chk("G_no_frame_done", 32'(nfd), 32'd0);
    chk("G_busy_idle", 32'(busy3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
